id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding stage that sits directly upstream of the 32-bit ALU.
- Latches decoded instruction fields and register-file data each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's a, b, f and shamt inputs.
- Flags load-use hazards so the decode stage can stall.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- F_W, 4, ALU function-code width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs / id_rt / id_rd  in  RA_W each  source and destination register numbers.
- id_rs_data / id_rt_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  extended immediate.
- id_use_imm  in  1  ALU b takes id_imm instead of rt.
- id_alu_f  in  F_W  ALU function code.
- id_shamt  in  5  shift amount.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- stall  in  1  hold the EX register.
- flush  in  1  load a bubble into EX.
- exm_reg_write  in  1  EX/MEM write enable.
- exm_rd  in  RA_W  EX/MEM destination register.
- exm_result  in  XLEN  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB write enable.
- mwb_rd  in  RA_W  MEM/WB destination register.
- mwb_result  in  XLEN  MEM/WB result.
- ex_valid  out  1  EX register holds a real instruction.
- alu_a / alu_b  out  XLEN each  ALU operands.
- alu_f  out  F_W  ALU function code.
- alu_shamt  out  5  ALU shift amount.
- ex_store_data  out  XLEN  forwarded rt value, used by stores.
- ex_rd  out  RA_W  EX destination register.
- ex_reg_write  out  1  EX write enable.
- ex_mem_read  out  1  EX instruction is a load.
- load_use_hazard  out  1  combinational stall request to decode.

Behaviour:
- Reset (rst_n low, asynchronous): every EX register clears to 0, so ex_valid=0, alu_f=0000 (ADD), alu_shamt=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
  - With the register zeroed and no forwarding, alu_a=alu_b=0 and ex_store_data=0.
- Register update on rising clk, priority flush > stall > load:
  - flush: bubble. All EX fields are 0, including ex_valid, ex_reg_write and ex_mem_read.
  - stall (no flush): all EX fields hold.
  - otherwise: capture all id_* fields. ex_valid=id_valid; ex_reg_write=id_reg_write&id_valid; ex_mem_read=id_mem_read&id_valid.
- Latency: one cycle from id_* inputs to alu_f, alu_shamt, ex_rd and control outputs. alu_a, alu_b and ex_store_data are combinational from the EX register plus the forward inputs.
- Forwarding, applied independently to latched rs (giving fwd_a) and latched rt (giving fwd_b):
  - If exm_reg_write and exm_rd!=0 and exm_rd==src, use exm_result.
  - Else if mwb_reg_write and mwb_rd!=0 and mwb_rd==src, use mwb_result.
  - Else use the latched register data.
  - Register 0 is never forwarded. When both EX/MEM and MEM/WB match, EX/MEM wins.
- Operand selection: alu_a=fwd_a; alu_b = ex_use_imm ? ex_imm : fwd_b; ex_store_data=fwd_b always.
- load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (id_rs==ex_rd | id_rt==ex_rd).
  - It is purely combinational. It does not itself stall this block; the upstream controller issues stall on ID and flush on this stage.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall clears everything immediately.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_a and fwd_b are the latched register data, and no forward muxes are present.
  - load_use_hazard widens to a full RAW stall: it asserts when id_valid and id_rs or id_rt is nonzero and equals either:
    - ex_rd while ex_reg_write is set, or
    - exm_rd while exm_reg_write is set.
  - MEM/WB is covered by the write-first register file.

Decomposition:
- Package ex_pkg holds:
  - ALU function-code localparams: ALU_ADD=0000 … ALU_LUI=1110.
  - XLEN, RA_W, F_W.
  - REG_ZERO.
  - A packed struct id_ex_t for the latched fields.
- One sub-module, ex_fwd_unit: combinational. Inputs are src, reg_data and the exm/mwb triples; output is the forwarded data. It is instantiated twice, for rs and rt.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, ex_valid=0.
- Plain load: load rs=3 (data 5), rt=4 (data 7), f=0000, no forward matches -> next cycle alu_a=5, alu_b=7, alu_f=0000, ex_valid=1.
- Forward priority: EX rs=8; exm_rd=8 result 0x11; mwb_rd=8 result 0x22 -> alu_a=0x11. Drop exm_reg_write -> alu_a=0x22. Set rs=0 with exm_rd=0 -> latched data, no forward.
- Immediate path: id_use_imm=1, imm=0x1234, rt=9 with exm_rd=9 result 0xAB -> alu_b=0x1234, ex_store_data=0xAB.
- Load-use hazard: EX holds a load with rd=5; ID has id_rs=5 -> load_use_hazard=1. Next edge stall=1 and flush=1 together -> bubble loaded, ex_valid=0, ex_reg_write=0.
- Stall hold: stall=1 for 3 cycles while id_* inputs change -> EX outputs unchanged. Release stall -> new fields appear after one edge.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and constants for the ID/EX operand stage
package ex_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int F_W  = 4;

    localparam logic [RA_W-1:0] REG_ZERO = '0;

    // ALU function codes
    localparam logic [F_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [F_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [F_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [F_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [F_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [F_W-1:0] ALU_NOR  = 4'b0101;
    localparam logic [F_W-1:0] ALU_SLT  = 4'b0110;
    localparam logic [F_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [F_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [F_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [F_W-1:0] ALU_SRA  = 4'b1010;
    localparam logic [F_W-1:0] ALU_SLLV = 4'b1011;
    localparam logic [F_W-1:0] ALU_SRLV = 4'b1100;
    localparam logic [F_W-1:0] ALU_SRAV = 4'b1101;
    localparam logic [F_W-1:0] ALU_LUI  = 4'b1110;

    // Fields latched into the EX register
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [F_W-1:0]  alu_f;
        logic [4:0]      shamt;
        logic            reg_write;
        logic            mem_read;
    } id_ex_t;

endpackage

// File: rtl/ex_fwd_unit.sv
// rtl/ex_fwd_unit.sv - operand forward mux from EX/MEM and MEM/WB
// Ports: src_i (source register), reg_data_i (latched register data),
//        exm_*_i / mwb_*_i (producer write enable, rd, result),
//        fwd_data_o (operand value after forwarding).
// Macro ID_EX_FORWARD_EN: when undefined the unit is a pass-through of reg_data_i.
import ex_pkg::*;

module ex_fwd_unit (
    input  logic [RA_W-1:0] src_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            exm_reg_write_i,
    input  logic [RA_W-1:0] exm_rd_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic            mwb_reg_write_i,
    input  logic [RA_W-1:0] mwb_rd_i,
    input  logic [XLEN-1:0] mwb_result_i,
    output logic [XLEN-1:0] fwd_data_o
);

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
    always_comb begin
        fwd_data_o = reg_data_i;
        if (exm_reg_write_i && (exm_rd_i != REG_ZERO) && (exm_rd_i == src_i)) begin
            fwd_data_o = exm_result_i;
        end else if (mwb_reg_write_i && (mwb_rd_i != REG_ZERO) && (mwb_rd_i == src_i)) begin
            fwd_data_o = mwb_result_i;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{src_i, exm_reg_write_i, exm_rd_i, exm_result_i,
                                 mwb_reg_write_i, mwb_rd_i, mwb_result_i};
    assign fwd_data_o = reg_data_i;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with operand forwarding feeding the ALU
// Ports: id_* decoded fields in; stall/flush register control; exm_*/mwb_*
//        forwarding sources; alu_a/alu_b/alu_f/alu_shamt ALU drive;
//        ex_* EX-stage status; load_use_hazard combinational stall request.
// Macro ID_EX_FORWARD_EN: enables forwarding; undefined widens load_use_hazard
// into a full RAW interlock against EX and EX/MEM.
import ex_pkg::*;

module id_ex_operand_stage (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [F_W-1:0]  id_alu_f,
    input  logic [4:0]      id_shamt,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            stall,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [F_W-1:0]  alu_f,
    output logic [4:0]      alu_shamt,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            load_use_hazard
);

    id_ex_t ex_q, ex_d;
    logic [XLEN-1:0] fwd_a, fwd_b;

    // flush > stall > load; side effects of an invalid instruction are masked on capture
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid     = id_valid;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd        = id_rd;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = id_imm;
            ex_d.use_imm   = id_use_imm;
            ex_d.alu_f     = id_alu_f;
            ex_d.shamt     = id_shamt;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.mem_read  = id_mem_read & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    ex_fwd_unit u_fwd_rs (
        .src_i           (ex_q.rs),
        .reg_data_i      (ex_q.rs_data),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .fwd_data_o      (fwd_a)
    );

    ex_fwd_unit u_fwd_rt (
        .src_i           (ex_q.rt),
        .reg_data_i      (ex_q.rt_data),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .fwd_data_o      (fwd_b)
    );

    assign alu_a         = fwd_a;
    assign alu_b         = ex_q.use_imm ? ex_q.imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign alu_f         = ex_q.alu_f;
    assign alu_shamt     = ex_q.shamt;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot be covered by forwarding.
    assign load_use_hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != REG_ZERO)
                           & ((id_rs == ex_q.rd) | (id_rt == ex_q.rd));
`else
    // Without forwarding every pending write in EX or EX/MEM must drain;
    // MEM/WB is covered by the write-first register file.
    logic rs_raw, rt_raw;
    assign rs_raw = (id_rs != REG_ZERO)
                  & ((ex_q.reg_write & (id_rs == ex_q.rd)) | (exm_reg_write & (id_rs == exm_rd)));
    assign rt_raw = (id_rt != REG_ZERO)
                  & ((ex_q.reg_write & (id_rt == ex_q.rd)) | (exm_reg_write & (id_rt == exm_rd)));
    assign load_use_hazard = id_valid & (rs_raw | rt_raw);
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_f;
    logic [4:0]  id_shamt;
    logic        id_reg_write, id_mem_read;
    logic        stall, flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_f;
    logic [4:0]  alu_shamt, ex_rd;
    logic        ex_reg_write, ex_mem_read, load_use_hazard;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_f(id_alu_f), .id_shamt(id_shamt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_shamt(alu_shamt), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [3:0] f, input logic [4:0] sh,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
        id_rd = rd; id_alu_f = f; id_shamt = sh; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clr_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; id_imm = 0; id_use_imm = 0;
        clr_fwd();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1;

        // Reset asserted mid-cycle clears a loaded instruction at once
        set_id(1, 3, 32'h33, 4, 32'h44, 7, 4'd3, 5'd9, 1, 1);
        tick();
        chk("preload_valid", {31'b0, ex_valid}, 1);
        #3 rst_n = 0;
        #1;
        chk("rst_valid", {31'b0, ex_valid}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_ctrl", {20'b0, alu_f, alu_shamt, ex_rd, ex_reg_write, ex_mem_read}, 0);
        rst_n = 1;

        // Plain load, no forwarding
        set_id(1, 3, 32'd5, 4, 32'd7, 10, 4'b0000, 0, 1, 0);
        tick();
        chk("plain_alu_a", alu_a, 5);
        chk("plain_alu_b", alu_b, 7);
        chk("plain_alu_f", {28'b0, alu_f}, 0);
        chk("plain_valid", {31'b0, ex_valid}, 1);
        chk("plain_rd_rw", {26'b0, ex_rd, ex_reg_write}, {26'b0, 5'd10, 1'b1});

        // Forward priority on rs
        set_id(1, 8, 32'h99, 4, 32'd7, 11, 4'd1, 0, 1, 0);
        tick();
        exm_reg_write = 1; exm_rd = 8; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 8; mwb_result = 32'h22;
        #1;
        chk("fwd_exm_wins", alu_a, FWD ? 32'h11 : 32'h99);
        exm_reg_write = 0;
        #1;
        chk("fwd_mwb", alu_a, FWD ? 32'h22 : 32'h99);
        chk("fwd_rt_untouched", alu_b, 7);
        exm_reg_write = 1; exm_rd = 0; mwb_rd = 0;
        set_id(1, 0, 32'h55, 4, 32'd7, 11, 4'd1, 0, 1, 0);
        tick();
        chk("fwd_r0_never", alu_a, 32'h55);
        clr_fwd();

        // Immediate selects b while store data still forwards rt
        id_use_imm = 1; id_imm = 32'h1234;
        set_id(1, 2, 32'd1, 9, 32'h77, 12, 4'd0, 0, 1, 0);
        tick();
        exm_reg_write = 1; exm_rd = 9; exm_result = 32'hAB;
        #1;
        chk("imm_alu_b", alu_b, 32'h1234);
        chk("imm_store_fwd", ex_store_data, FWD ? 32'hAB : 32'h77);
        clr_fwd();
        id_use_imm = 0; id_imm = 0;

        // Invalid instruction masks its write/load enables
        set_id(0, 1, 0, 2, 0, 13, 4'd0, 0, 1, 1);
        tick();
        chk("inval_masked", {29'b0, ex_valid, ex_reg_write, ex_mem_read}, 0);

        // Load-use hazard, then simultaneous stall+flush
        set_id(1, 1, 0, 2, 0, 5, 4'd0, 0, 1, 1);
        tick();
        chk("load_in_ex", {30'b0, ex_mem_read, ex_reg_write}, 3);
        set_id(1, 5, 0, 6, 0, 8, 4'd0, 0, 1, 0);
        #1;
        chk("lu_hazard_rs", {31'b0, load_use_hazard}, 1);
        id_rs = 6; id_rt = 5;
        #1;
        chk("lu_hazard_rt", {31'b0, load_use_hazard}, 1);
        id_rt = 7;
        #1;
        chk("lu_no_hazard", {31'b0, load_use_hazard}, 0);
        id_rs = 5;
        stall = 1; flush = 1;
        tick();
        chk("flush_bubble", {26'b0, ex_valid, ex_reg_write, ex_mem_read, ex_rd[2:0]}, 0);
        chk("flush_alu_a", alu_a, 0);
        stall = 0; flush = 0;
        // EX/MEM producer: covered by forwarding, interlocked without it
        set_id(1, 12, 0, 0, 0, 1, 4'd0, 0, 0, 0);
        exm_reg_write = 1; exm_rd = 12;
        #1;
        chk("raw_exm_hazard", {31'b0, load_use_hazard}, FWD ? 32'd0 : 32'd1);
        clr_fwd();

        // Stall holds EX for 3 cycles while ID changes
        set_id(1, 1, 32'hA1, 2, 32'hB2, 3, 4'd5, 5'd7, 1, 0);
        tick();
        chk("pre_stall_f", {28'b0, alu_f}, 5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 1, 32'hF0 + i, 2, 32'hC0 + i, 5'(20 + i), 4'(i), 5'(10 + i), 1, 0);
            tick();
            chk("stall_hold_a", alu_a, 32'hA1);
            chk("stall_hold_ctl", {16'b0, alu_f, alu_shamt, ex_rd, 2'b0},
                {16'b0, 4'd5, 5'd7, 5'd3, 2'b0});
        end
        stall = 0;
        tick();
        chk("release_a", alu_a, 32'hF2);
        chk("release_ctl", {18'b0, alu_f, alu_shamt, ex_rd}, {18'b0, 4'd2, 5'd12, 5'd22});

        // Reset during stall clears immediately
        stall = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_in_stall", {27'b0, ex_valid, alu_f}, 0);
        chk("rst_in_stall_b", alu_b, 0);
        rst_n = 1; stall = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
